alu: RTL and testbench

16-bit arithmetic/logic/shift unit for the simple-asm CPU datapath, with a registered S/Z/C/V flag register and a branch-condition evaluator.
- The result and flag outputs are combinational from the operands and the operation select.
- The controller latches ALU_OUT into DR in phase 3 and pulses FLAG_EN in phase 5 to commit flags.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_if.sv | 18 +
 rtl/alu_shifter.sv | 28 ++
 rtl/alu.sv | 85 ++++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag-index and branch-condition encodings shared by the ALU and the controller
package alu_pkg;
    localparam int WIDTH = 16;
    localparam logic [3:0] IADD  = 4'b0000;
    localparam logic [3:0] ISUB  = 4'b0001;
    localparam logic [3:0] IAND  = 4'b0010;
    localparam logic [3:0] IOR   = 4'b0011;
    localparam logic [3:0] IXOR  = 4'b0100;
    localparam logic [3:0] ICMP  = 4'b0101;
    localparam logic [3:0] IMOV  = 4'b0110;
    localparam logic [3:0] ISLL  = 4'b1000;
    localparam logic [3:0] ISLR  = 4'b1001;
    localparam logic [3:0] ISRL  = 4'b1010;
    localparam logic [3:0] ISRA  = 4'b1011;
    localparam logic [3:0] IIDT  = 4'b1100;
    localparam logic [3:0] IOUT  = 4'b1101;
    localparam logic [3:0] IHALT = 4'b1111;
    localparam int FLAG_S = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    // shift kinds line up with the low two bits of the shift opcodes
    typedef enum logic [1:0] {SH_SLL, SH_SLR, SH_SRL, SH_SRA} shift_kind_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the datapath controller and the ALU
interface alu_if;
    import alu_pkg::*;
    logic [3:0]       S_ALU;
    logic [WIDTH-1:0] DATA_A;
    logic [WIDTH-1:0] DATA_B;
    logic             FLAG_EN;
    logic [2:0]       COND_SEL;
    logic [WIDTH-1:0] ALU_OUT;
    logic [3:0]       FLAG_OUT;
    logic             FLAG_WRITE;
    logic [3:0]       FLAGS_Q;
    logic             TAKEN;
    modport master (output S_ALU, DATA_A, DATA_B, FLAG_EN, COND_SEL,
                    input  ALU_OUT, FLAG_OUT, FLAG_WRITE, FLAGS_Q, TAKEN);
    modport slave  (input  S_ALU, DATA_A, DATA_B, FLAG_EN, COND_SEL,
                    output ALU_OUT, FLAG_OUT, FLAG_WRITE, FLAGS_Q, TAKEN);
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: shift/rotate by 0-15 with the last bit shifted out as carry
module alu_shifter
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [3:0]       amount,
    input  shift_kind_t      kind,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0]   left;
    logic [WIDTH:0]   right;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] rot;
    // one guard bit beyond each end catches the last bit shifted out
    always_comb begin
        left   = {1'b0, a} << amount;
        right  = {a, 1'b0} >> amount;
        arith  = $signed({a, 1'b0}) >>> amount;
        rot    = (a << amount) | (a >> (5'd16 - {1'b0, amount}));
        result = kind == SH_SLL ? left[WIDTH-1:0] :
                 kind == SH_SLR ? rot :
                 kind == SH_SRL ? right[WIDTH:1] : arith[WIDTH:1];
        carry  = kind == SH_SLL ? left[WIDTH] :
                 kind == SH_SLR ? (amount != 4'd0) && rot[0] :
                 kind == SH_SRL ? right[0] : arith[0];
    end
endmodule

// File: rtl/alu.sv
// alu: 16-bit ALU with committed S/Z/C/V flag register and branch-condition evaluator
module alu
    import alu_pkg::*;
(
    input logic clock,
    input logic reset,
    alu_if.slave bus
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sh_res;
    logic [3:0]       flags;
    logic [3:0]       q;
    logic             sh_c;
    logic             c;
    logic             v;
    logic             fw;
    logic             z;
    logic             sv;
    assign a = bus.DATA_A;
    assign b = bus.DATA_B;
    alu_shifter u_shift (
        .a(a),
        .amount(b[3:0]),
        .kind(shift_kind_t'(bus.S_ALU[1:0])),
        .result(sh_res),
        .carry(sh_c)
    );
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        fw   = 1'b1;
        case (bus.S_ALU)
            IADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            ISUB, ICMP: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            IAND: res = a & b;
            IOR:  res = a | b;
            IXOR: res = a ^ b;
            IMOV: res = b;
            ISLL, ISLR, ISRL, ISRA: begin
                res = sh_res;
                c   = sh_c;
            end
            IIDT: begin
                res = b;
                fw  = 1'b0;
            end
            IOUT: begin
                res = a;
                fw  = 1'b0;
            end
            default: fw = 1'b0;
        endcase
        flags = fw ? {v, c, res == '0, res[WIDTH-1]} : 4'b0000;
    end
    always_ff @(posedge clock)
        if (reset)
            q <= 4'b0000;
        else if (bus.FLAG_EN && fw)
            q <= flags;
    assign z  = q[FLAG_Z];
    assign sv = q[FLAG_S] ^ q[FLAG_V];
    assign bus.ALU_OUT    = res;
    assign bus.FLAG_OUT   = flags;
    assign bus.FLAG_WRITE = fw;
    assign bus.FLAGS_Q    = q;
    assign bus.TAKEN      = bus.COND_SEL == COND_BE  ? z :
                            bus.COND_SEL == COND_BLT ? sv :
                            bus.COND_SEL == COND_BLE ? z | sv :
                            bus.COND_SEL == COND_BNE ? !z : 1'b0;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed plan steps plus random ops against an arithmetic reference model
module tb_alu;
    import alu_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [3:0] fq = 4'b0000;
    bit fq_known = 1'b0;
    logic [3:0] saved;

    alu_if bus();
    alu dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f, output logic fw);
        int ua, ub, sa, sb, n, t;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        c  = 1'b0;
        v  = 1'b0;
        fw = 1'b1;
        r  = 16'h0000;
        case (op)
            IADD: begin
                t = ua + ub; r = 16'(t); c = t > 65535;
                t = sa + sb; v = t > 32767 || t < -32768;
            end
            ISUB, ICMP: begin
                t = ua - ub; r = 16'(t); c = ua < ub;
                t = sa - sb; v = t > 32767 || t < -32768;
            end
            IAND: r = a & b;
            IOR:  r = a | b;
            IXOR: r = a ^ b;
            IMOV: r = b;
            ISLL: begin
                r = 16'(ua << n);
                c = n != 0 && ((ua >> (16 - n)) & 1) != 0;
            end
            ISLR: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = r[15];
                    r = {r[14:0], r[15]};
                end
            end
            ISRL: begin
                r = 16'(ua >> n);
                c = n != 0 && ((ua >> (n - 1)) & 1) != 0;
            end
            ISRA: begin
                r = 16'(sa >>> n);
                c = n != 0 && ((sa >>> (n - 1)) & 1) != 0;
            end
            IIDT: begin r = b; fw = 1'b0; end
            IOUT: begin r = a; fw = 1'b0; end
            default: fw = 1'b0;
        endcase
        f = fw ? {v, c, r == 16'h0000, r[15]} : 4'b0000;
    endfunction

    function automatic logic taken_of(input logic [3:0] q, input logic [2:0] cs);
        logic s, z, v;
        s = q[0];
        z = q[1];
        v = q[3];
        case (cs)
            3'd0: return z;
            3'd1: return s != v;
            3'd2: return z || (s != v);
            3'd3: return !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic en, input logic [2:0] cs, input logic rst, input string tag);
        logic [15:0] r;
        logic [3:0] f;
        logic fw;
        @(negedge clock);
        bus.S_ALU    = op;
        bus.DATA_A   = a;
        bus.DATA_B   = b;
        bus.FLAG_EN  = en;
        bus.COND_SEL = cs;
        reset        = rst;
        #1;
        model(op, a, b, r, f, fw);
        chk({tag, "_out"}, bus.ALU_OUT, r);
        chk({tag, "_flags"}, 16'(bus.FLAG_OUT), 16'(f));
        chk({tag, "_fw"}, 16'(bus.FLAG_WRITE), 16'(fw));
        if (fq_known) begin
            chk({tag, "_q_pre"}, 16'(bus.FLAGS_Q), 16'(fq));
            chk({tag, "_taken_pre"}, 16'(bus.TAKEN), 16'(taken_of(fq, cs)));
        end
        @(posedge clock);
        if (rst) begin
            fq = 4'b0000;
            fq_known = 1'b1;
        end else if (en && fw) begin
            fq = f;
            fq_known = 1'b1;
        end
        #1;
        if (fq_known) begin
            chk({tag, "_q"}, 16'(bus.FLAGS_Q), 16'(fq));
            chk({tag, "_taken"}, 16'(bus.TAKEN), 16'(taken_of(fq, cs)));
        end
    endtask

    initial begin
        bus.S_ALU    = IADD;
        bus.DATA_A   = 16'h0000;
        bus.DATA_B   = 16'h0000;
        bus.FLAG_EN  = 1'b0;
        bus.COND_SEL = 3'b100;
        apply(IADD, 16'h0000, 16'h0000, 1'b1, 3'b100, 1'b1, "rst");
        chk("rst_q0", 16'(bus.FLAGS_Q), 16'h0000);

        apply(IADD, 16'h7FFF, 16'h0001, 1'b0, COND_BE, 1'b0, "p1");
        chk("p1_sum", bus.ALU_OUT, 16'h8000);
        chk("p1_fout", 16'(bus.FLAG_OUT), 16'h0009);
        chk("p1_fw", 16'(bus.FLAG_WRITE), 16'h0001);
        apply(IADD, 16'h7FFF, 16'h0001, 1'b1, COND_BE, 1'b0, "p1c");
        chk("p1_commit", 16'(bus.FLAGS_Q), 16'h0009);

        apply(ISUB, 16'h0003, 16'h0005, 1'b0, COND_BE, 1'b0, "p2");
        chk("p2_diff", bus.ALU_OUT, 16'hFFFE);
        chk("p2_fout", 16'(bus.FLAG_OUT), 16'h0005);

        apply(ICMP, 16'h1234, 16'h1234, 1'b1, COND_BE, 1'b0, "p3");
        chk("p3_out", bus.ALU_OUT, 16'h0000);
        chk("p3_q", 16'(bus.FLAGS_Q), 16'h0002);
        apply(IAND, 16'h0000, 16'h0000, 1'b0, COND_BE, 1'b0, "p3be");
        chk("p3_be", 16'(bus.TAKEN), 16'h0001);
        apply(IAND, 16'h0000, 16'h0000, 1'b0, COND_BNE, 1'b0, "p3bne");
        chk("p3_bne", 16'(bus.TAKEN), 16'h0000);

        apply(ISLL, 16'h8001, 16'h0001, 1'b0, COND_BE, 1'b0, "sll");
        chk("sll_out", bus.ALU_OUT, 16'h0002);
        chk("sll_c", 16'(bus.FLAG_OUT[FLAG_C]), 16'h0001);
        apply(ISLR, 16'h8001, 16'h0004, 1'b0, COND_BE, 1'b0, "slr");
        chk("slr_out", bus.ALU_OUT, 16'h0018);
        apply(ISRA, 16'h8000, 16'h000F, 1'b0, COND_BE, 1'b0, "sra");
        chk("sra_out", bus.ALU_OUT, 16'hFFFF);
        apply(ISRL, 16'h8000, 16'h000F, 1'b0, COND_BE, 1'b0, "srl");
        chk("srl_out", bus.ALU_OUT, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            apply(ISLL + 4'(k), 16'hA5A5, 16'h00F0, 1'b1, COND_BLT, 1'b0, "sh0");
            chk("sh0_out", bus.ALU_OUT, 16'hA5A5);
            chk("sh0_c", 16'(bus.FLAG_OUT[FLAG_C]), 16'h0000);
        end

        saved = bus.FLAGS_Q;
        apply(IOUT, 16'h00AB, 16'h0000, 1'b1, COND_BE, 1'b0, "p5");
        chk("p5_out", bus.ALU_OUT, 16'h00AB);
        chk("p5_fw", 16'(bus.FLAG_WRITE), 16'h0000);
        chk("p5_hold", 16'(bus.FLAGS_Q), 16'h0001);
        chk("p5_same", 16'(bus.FLAGS_Q), 16'(saved));

        apply(ISUB, 16'h0003, 16'h0005, 1'b1, COND_BE, 1'b0, "p6a");
        apply(IADD, 16'h7FFF, 16'h0001, 1'b1, COND_BE, 1'b1, "p6");
        chk("p6_rst", 16'(bus.FLAGS_Q), 16'h0000);
        apply(ICMP, 16'h0042, 16'h0042, 1'b1, COND_BE, 1'b0, "p6z");
        for (int k = 4; k < 8; k++) begin
            apply(IAND, 16'h0000, 16'h0000, 1'b0, 3'(k), 1'b0, "p6n");
            chk("p6_never", 16'(bus.TAKEN), 16'h0000);
        end

        for (int i = 0; i < 400; i++) begin
            logic [15:0] rb;
            rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            apply(4'($urandom_range(0, 15)), 16'($urandom), rb, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 31) == 0), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
